mux21_arbiter: RTL
==================

// Module: mux21_arbiter
// PURPOSE
//  Round-robin arbiter sharing one WIDTH-bit 2:1 mux datapath between two requesters.
//  Each requester raises req and holds it while it owns the path.
//  The block grants one requester at a time and drives the mux select from a registered grant.
//  A hold limit forces rotation so neither side starves. Sits in front of the downstream consumer of y.
// PARAMETERS
//  WIDTH     8   data width of d1/d2/y (one mux21 slice per bit)
//  MAX_HOLD  15  max consecutive granted cycles while the other side waits; >=1
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      synchronous reset, active-high
//  req1   in   1      requester 1 wants the path; hold high while using it
//  req2   in   1      requester 2 wants the path; hold high while using it
//  d1     in   WIDTH  requester 1 data
//  d2     in   WIDTH  requester 2 data
//  gnt1   out  1      requester 1 owns the path (registered)
//  gnt2   out  1      requester 2 owns the path (registered)
//  sel    out  1      mux select: 0=d1, 1=d2 (registered)
//  y      out  WIDTH  muxed data = sel ? d2 : d1 (combinational from sel)
//  valid  out  1      gnt1|gnt2; y carries the granted requester's data
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE, gnt1=gnt2=0, sel=0, valid=0, hold_cnt=0, last=2.
//    last=2 gives req1 priority on the first tie. rst overrides everything, mid-grant included.
//  - States: IDLE, G1, G2. gnt1=(G1), gnt2=(G2); gnt1&gnt2 never both 1.
//  - Latency: req seen at edge n -> gnt/sel/valid updated at edge n+1 (1 cycle).
//  - IDLE:
//      req1 only -> G1. req2 only -> G2.
//      Both -> the side not equal to last. No req -> stay IDLE.
//  - G1 (G2 symmetric):
//      req1=0 -> G2 if req2, else IDLE; last<=1.
//      req1=1 & req2=1 & hold_cnt==MAX_HOLD-1 -> forced G2; last<=1.
//      Otherwise stay; hold_cnt++.
//  - hold_cnt rules:
//      Cleared on every grant change and in IDLE.
//      Increments only while the other req is high.
//      Saturates at MAX_HOLD-1; no wrap.
//      With no competitor, a grant is held indefinitely.
//  - Switches are back-to-back: G1->G2 with no IDLE gap; valid stays 1 across the switch.
//  - Preempted requester keeps req high: it is simply waiting and is regranted per the rules.
//  - sel updates with the grant. sel keeps its last value in IDLE; y is don't-care when valid=0.
//  - req dropped and re-raised in the same side's grant cycle: the drop is seen and the grant released.
//  - X on req during rst is ignored; no combinational path from req to gnt.
// STRUCTURE
//  - Shared header mux21_arbiter_defs.vh: state encodings ST_IDLE=2'd0, ST_G1=2'd1, ST_G2=2'd2.
//  - Sub-module: existing mux21 (1-bit), generate-instantiated WIDTH times.
//    Per bit: S=sel, D1=d1[i], D2=d2[i], Y=y[i].
//  - hold_cnt width = $clog2(MAX_HOLD+1).
// TESTING
//  1 Reset: rst=1 for 2 cycles with req1=req2=1 -> gnt1=gnt2=0, sel=0, valid=0; after release gnt1=1 next cycle.
//  2 Single: req2=1 at cycle 5, d2=8'hA5 -> cycle 6 gnt2=1, sel=1, y=8'hA5; req2=0 at 9 -> cycle 10 IDLE, valid=0, sel=1.
//  3 Tie rotation: req1=req2 pulse 1 cycle each, repeated from IDLE 4 times -> grants alternate 1,2,1,2.
//  4 Hold limit MAX_HOLD=4: req1 held, req2 raised at grant cycle 0 -> gnt1 for 4 cycles, then gnt2 next cycle, no gap.
//  5 No competitor: req1 high 40 cycles, req2=0 -> gnt1 stays 1 all 40 cycles, no forced switch.
//  6 Reset mid-grant: rst=1 while G2 with hold_cnt=2 -> next cycle IDLE, sel=0; tie afterwards goes to req1.

Source files
------------

// File: rtl/mux21_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux21_arbiter_pkg;

   // Arbiter ownership states; encodings are fixed so waveforms and
   // downstream debug tooling decode them consistently.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G1   = 2'd1,
      ST_G2   = 2'd2
   } state_t;

   // Which requester most recently gave up the path. Reset value LAST_2
   // makes requester 1 win the first tie.
   typedef enum logic [1:0] {
      LAST_1 = 2'd1,
      LAST_2 = 2'd2
   } last_t;

   // Width of the hold counter for a given hold limit.
   function automatic int hold_cnt_w(input int max_hold);
      return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/mux21_arbiter_mux21.sv
// One-bit 2:1 mux slice: y = s ? d2 : d1.
// Latency: combinational.
// Backpressure: none.
// Ports: s (select), d1/d2 (data inputs), y (selected output).
module mux21 (
   input  logic s,
   input  logic d1,
   input  logic d2,
   output logic y
);

   assign y = s ? d2 : d1;

endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 2:1 mux between two requesters.
// Latency: req sampled at edge n -> gnt/sel/valid at edge n+1; y follows sel combinationally.
// Backpressure: a holder keeps the path until it drops req or hits MAX_HOLD while the other waits.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   req1, req2      requests, held high while using the path
//   d1, d2          requester data
//   gnt1, gnt2      registered one-hot-or-zero grants
//   sel             registered mux select (0=d1, 1=d2), kept in IDLE
//   y               sel ? d2 : d1
//   valid           gnt1 | gnt2
module mux21_arbiter
   import mux21_arbiter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req1,
   input  logic             req2,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic             gnt1,
   output logic             gnt2,
   output logic             sel,
   output logic [WIDTH-1:0] y,
   output logic             valid
);

   localparam int CNT_W = hold_cnt_w(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_nxt;
   last_t            last_q, last_nxt;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_nxt;
   logic             sel_q, sel_nxt;

   // State register. rst wins over everything, including an active grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_q     <= LAST_2;
         hold_cnt_q <= '0;
         sel_q      <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         last_q     <= last_nxt;
         hold_cnt_q <= hold_cnt_nxt;
         sel_q      <= sel_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt    = state_q;
      last_nxt     = last_q;
      hold_cnt_nxt = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            hold_cnt_nxt = '0;
            if (req1 && req2) begin
               // Tie: favour whoever did not release most recently.
               state_nxt = (last_q == LAST_2) ? ST_G1 : ST_G2;
            end else if (req1) begin
               state_nxt = ST_G1;
            end else if (req2) begin
               state_nxt = ST_G2;
            end
         end

         ST_G1: begin
            if (!req1) begin
               state_nxt    = req2 ? ST_G2 : ST_IDLE;
               last_nxt     = LAST_1;
               hold_cnt_nxt = '0;
            end else if (req2 && (hold_cnt_q == HOLD_TOP)) begin
               state_nxt    = ST_G2;
               last_nxt     = LAST_1;
               hold_cnt_nxt = '0;
            end else if (req2 && (hold_cnt_q != HOLD_TOP)) begin
               // Only counts while the other side is waiting; never wraps.
               hold_cnt_nxt = hold_cnt_q + CNT_ONE;
            end
         end

         ST_G2: begin
            if (!req2) begin
               state_nxt    = req1 ? ST_G1 : ST_IDLE;
               last_nxt     = LAST_2;
               hold_cnt_nxt = '0;
            end else if (req1 && (hold_cnt_q == HOLD_TOP)) begin
               state_nxt    = ST_G1;
               last_nxt     = LAST_2;
               hold_cnt_nxt = '0;
            end else if (req1 && (hold_cnt_q != HOLD_TOP)) begin
               hold_cnt_nxt = hold_cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
         end
      endcase

      // sel tracks the grant and keeps its value while idle.
      case (state_nxt)
         ST_G1:   sel_nxt = 1'b0;
         ST_G2:   sel_nxt = 1'b1;
         default: sel_nxt = sel_q;
      endcase
   end

   // Outputs decode the registered state only; no path from req to gnt.
   always_comb begin
      gnt1  = (state_q == ST_G1);
      gnt2  = (state_q == ST_G2);
      valid = (state_q == ST_G1) || (state_q == ST_G2);
      sel   = sel_q;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      mux21 u_mux21 (
         .s  (sel_q),
         .d1 (d1[i]),
         .d2 (d2[i]),
         .y  (y[i])
      );
   end

endmodule
